// File: rtl/cvec_player_pkg.sv
// Shared constants for cvec_player: IQ field layout, FSM states, output FIFO depth.
// Also provides the saturating conjugate used when CVEC_PLAYER_CONJ_EN is defined.
package cvec_player_pkg;

  localparam int unsigned IMsb = 31;
  localparam int unsigned ILsb = 16;
  localparam int unsigned QMsb = 15;
  localparam int unsigned QLsb = 0;

  localparam int unsigned FifoDepth = 2;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDrain
  } state_e;

  // Negate Q; -32768 has no positive counterpart so it saturates to 32767.
  function automatic logic [31:0] conj_iq(input logic [31:0] iq);
    logic [15:0] q;
    logic [15:0] q_neg;
    q = iq[QMsb:QLsb];
    q_neg = (q == 16'h8000) ? 16'h7fff : (~q + 16'd1);
    return {iq[IMsb:ILsb], q_neg};
  endfunction

endpackage

// File: rtl/cvec_ram.sv
// Simple dual-port RAM with one-cycle registered read; a same-address
// write and read in one cycle returns the old contents.
module cvec_ram #(
  parameter int unsigned AddrWidth = 10,
  parameter int unsigned DataWidth = 32
) (
  input  logic                 clk_i,
  input  logic                 wr_en_i,
  input  logic [AddrWidth-1:0] wr_addr_i,
  input  logic [DataWidth-1:0] wr_data_i,
  input  logic                 rd_en_i,
  input  logic [AddrWidth-1:0] rd_addr_i,
  output logic [DataWidth-1:0] rd_data_o
);

  logic [DataWidth-1:0] mem_q [0:(1 << AddrWidth) - 1];
  logic [DataWidth-1:0] rd_data_q;

  always_ff @(posedge clk_i) begin
    if (wr_en_i) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
    if (rd_en_i) begin
      rd_data_q <= mem_q[rd_addr_i];
    end
  end

  assign rd_data_o = rd_data_q;

endmodule

// File: rtl/cvec_player.sv
// Replays a RAM table of complex coefficients as a 32-bit AXI-stream with tlast per vector.
// Optional macro CVEC_PLAYER_CONJ_EN adds a conj input that negates Q (saturating) per vector.
module cvec_player
  import cvec_player_pkg::*;
#(
  parameter int unsigned MAX_LEN_LOG2 = 10,
  parameter int unsigned RESET_LEN    = 2 ** MAX_LEN_LOG2
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    cfg_wr_en,
  input  logic [MAX_LEN_LOG2-1:0] cfg_wr_addr,
  input  logic [31:0]             cfg_wr_data,
  input  logic                    cfg_len_wr,
  input  logic [MAX_LEN_LOG2:0]   cfg_len,
  output logic                    cfg_err,
  input  logic                    enable,
  output logic                    busy,
  output logic [31:0]             o_tdata,
  output logic                    o_tlast,
  output logic                    o_tvalid,
  input  logic                    o_tready
`ifdef CVEC_PLAYER_CONJ_EN
  ,
  input  logic                    conj
`endif
);

  localparam int unsigned AW     = MAX_LEN_LOG2;
  localparam int unsigned LW     = MAX_LEN_LOG2 + 1;
  localparam int unsigned MaxLen = 1 << MAX_LEN_LOG2;

  state_e         state_q, state_d;
  logic [AW-1:0]  rd_addr_q, rd_addr_d;
  logic [LW-1:0]  len_shadow_q, len_shadow_d;
  logic [LW-1:0]  len_active_q, len_active_d;
  logic           drain_done_q, drain_done_d;
  logic           rd_valid_q, rd_valid_d;
  logic           rd_last_q, rd_last_d;
  logic           cfg_err_q, cfg_err_d;
  logic           busy_q, busy_d;
  logic [31:0]    o_tdata_q, o_tdata_d;
  logic           o_tlast_q, o_tlast_d;
  logic           o_tvalid_q, o_tvalid_d;
  logic [31:0]    skid_data_q, skid_data_d;
  logic           skid_last_q, skid_last_d;
  logic           skid_valid_q, skid_valid_d;

  logic           len_ok;
  logic [LW-1:0]  cur_len;
  logic [AW-1:0]  rd_addr;
  logic           rd_last;
  logic           rd_en;
  logic           pop;
  logic [1:0]     occ;
  logic           room;
  logic [31:0]    ram_data;
  logic [31:0]    push_data;

  cvec_ram #(
    .AddrWidth(AW),
    .DataWidth(32)
  ) u_ram (
    .clk_i    (clk),
    .wr_en_i  (cfg_wr_en),
    .wr_addr_i(cfg_wr_addr),
    .wr_data_i(cfg_wr_data),
    .rd_en_i  (rd_en),
    .rd_addr_i(rd_addr),
    .rd_data_o(ram_data)
  );

  always_comb begin
    len_ok       = (cfg_len != '0) && (cfg_len <= LW'(MaxLen));
    len_shadow_d = (cfg_len_wr && len_ok) ? cfg_len : len_shadow_q;
    cfg_err_d    = cfg_err_q | (cfg_len_wr & ~len_ok);
  end

  // Occupancy counts the in-flight RAM read so the 2-entry FIFO can never overflow;
  // subtracting this cycle's pop keeps the stream gapless at full rate.
  always_comb begin
    pop  = o_tvalid_q & o_tready;
    occ  = 2'(o_tvalid_q) + 2'(skid_valid_q) + 2'(rd_valid_q);
    room = (occ - 2'(pop)) < 2'(FifoDepth);
  end

  // A new length written in the same cycle as a vector start is forwarded.
  always_comb begin
    cur_len = (state_q == StIdle) ? len_shadow_d : len_active_q;
    rd_addr = (state_q == StIdle) ? '0 : rd_addr_q;
    rd_last = ({1'b0, rd_addr} == (cur_len - LW'(1)));
  end

  always_comb begin
    state_d      = state_q;
    rd_addr_d    = rd_addr_q;
    len_active_d = len_active_q;
    drain_done_d = drain_done_q;
    rd_en        = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (enable) begin
          rd_en        = 1'b1;
          state_d      = StRun;
          len_active_d = len_shadow_d;
        end
      end
      StRun: begin
        if (!enable) begin
          // Address 0 here means the previous vector is fully issued.
          state_d      = StDrain;
          rd_en        = room && (rd_addr_q != '0);
          drain_done_d = (rd_addr_q == '0) || (room && rd_last);
        end else begin
          rd_en = room;
        end
      end
      StDrain: begin
        if (!drain_done_q && room) begin
          rd_en        = 1'b1;
          drain_done_d = rd_last;
        end
        if (drain_done_q && !rd_valid_q && !skid_valid_q && (!o_tvalid_q || pop)) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
    if (rd_en) begin
      rd_addr_d = rd_last ? '0 : rd_addr + AW'(1);
      if (rd_last) begin
        len_active_d = len_shadow_d;
      end
    end
    busy_d     = (state_d != StIdle);
    rd_valid_d = rd_en;
    rd_last_d  = rd_last;
  end

`ifdef CVEC_PLAYER_CONJ_EN
  logic vec_conj_q, vec_conj_d;
  logic rd_conj_q, rd_conj_d;

  // conj is latched when entry 0 is issued and follows each read to the RAM output.
  always_comb begin
    rd_conj_d  = (rd_addr == '0) ? conj : vec_conj_q;
    vec_conj_d = (rd_en && (rd_addr == '0)) ? conj : vec_conj_q;
    push_data  = rd_conj_q ? conj_iq(ram_data) : ram_data;
  end
`else
  always_comb begin
    push_data = ram_data;
  end
`endif

  // Head register drives the outputs directly; skid catches the beat that
  // arrives while the head is stalled.
  always_comb begin
    o_tdata_d    = o_tdata_q;
    o_tlast_d    = o_tlast_q;
    o_tvalid_d   = o_tvalid_q;
    skid_data_d  = skid_data_q;
    skid_last_d  = skid_last_q;
    skid_valid_d = skid_valid_q;
    if (!o_tvalid_q || pop) begin
      if (skid_valid_q) begin
        o_tdata_d    = skid_data_q;
        o_tlast_d    = skid_last_q;
        o_tvalid_d   = 1'b1;
        skid_valid_d = rd_valid_q;
        if (rd_valid_q) begin
          skid_data_d = push_data;
          skid_last_d = rd_last_q;
        end
      end else begin
        o_tvalid_d = rd_valid_q;
        if (rd_valid_q) begin
          o_tdata_d = push_data;
          o_tlast_d = rd_last_q;
        end
      end
    end else if (rd_valid_q) begin
      skid_data_d  = push_data;
      skid_last_d  = rd_last_q;
      skid_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= StIdle;
      rd_addr_q    <= '0;
      len_shadow_q <= LW'(RESET_LEN);
      len_active_q <= LW'(RESET_LEN);
      drain_done_q <= 1'b0;
      rd_valid_q   <= 1'b0;
      rd_last_q    <= 1'b0;
      cfg_err_q    <= 1'b0;
      busy_q       <= 1'b0;
      o_tdata_q    <= '0;
      o_tlast_q    <= 1'b0;
      o_tvalid_q   <= 1'b0;
      skid_data_q  <= '0;
      skid_last_q  <= 1'b0;
      skid_valid_q <= 1'b0;
`ifdef CVEC_PLAYER_CONJ_EN
      vec_conj_q   <= 1'b0;
      rd_conj_q    <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      rd_addr_q    <= rd_addr_d;
      len_shadow_q <= len_shadow_d;
      len_active_q <= len_active_d;
      drain_done_q <= drain_done_d;
      rd_valid_q   <= rd_valid_d;
      rd_last_q    <= rd_last_d;
      cfg_err_q    <= cfg_err_d;
      busy_q       <= busy_d;
      o_tdata_q    <= o_tdata_d;
      o_tlast_q    <= o_tlast_d;
      o_tvalid_q   <= o_tvalid_d;
      skid_data_q  <= skid_data_d;
      skid_last_q  <= skid_last_d;
      skid_valid_q <= skid_valid_d;
`ifdef CVEC_PLAYER_CONJ_EN
      vec_conj_q   <= vec_conj_d;
      rd_conj_q    <= rd_conj_d;
`endif
    end
  end

  assign cfg_err  = cfg_err_q;
  assign busy     = busy_q;
  assign o_tdata  = o_tdata_q;
  assign o_tlast  = o_tlast_q;
  assign o_tvalid = o_tvalid_q;

endmodule

// File: doc/cvec_player.md
Name: cvec_player

Overview:
- Upstream stage that generates the b-stream for the complex multiplier.
- Holds a RAM table of up to 2^MAX_LEN_LOG2 complex coefficients, loaded through a simple write port.
- Replays the table continuously as a 32-bit AXI-stream, with tlast on the final entry of each vector.
- Output format is I in [31:16] and Q in [15:0], which matches the multiplier's b input directly.

Parameters:
- MAX_LEN_LOG2, 10: table depth is 2^MAX_LEN_LOG2 entries.
- RESET_LEN, 2^MAX_LEN_LOG2: vector length loaded at reset. Must be in the range 1..2^MAX_LEN_LOG2.

Ports:
- clk  in  1: single clock for the whole block.
- reset_n  in  1: reset, asynchronous, active-low.
- cfg_wr_en  in  1: write strobe for a table entry.
- cfg_wr_addr  in  MAX_LEN_LOG2: table write address.
- cfg_wr_data  in  32: table entry, {I[15:0], Q[15:0]}.
- cfg_len_wr  in  1: strobe to load a new vector length.
- cfg_len  in  MAX_LEN_LOG2+1: new vector length, legal range 1..2^MAX_LEN_LOG2.
- cfg_err  out  1: sticky flag, set on an illegal cfg_len write; cleared only by reset.
- enable  in  1: level signal; run while high.
- busy  out  1: high whenever the FSM is not IDLE.
- o_tdata  out  32: output sample.
- o_tlast  out  1: marks the last entry of a vector.
- o_tvalid  out  1: output valid.
- o_tready  in  1: output ready from downstream.

Behaviour:
- Reset values (reset_n low, asynchronous):
  - o_tvalid=0, o_tlast=0, o_tdata=0, busy=0, cfg_err=0.
  - Read address=0, len_active=len_shadow=RESET_LEN, FSM in IDLE, output FIFO empty.
  - RAM contents are not reset.
- Table writes:
  - Accepted in any state.
  - The RAM is simple dual-port with 1-cycle registered read.
  - If a write and a read hit the same address in the same cycle, the read returns the old data.
- Length writes:
  - A cfg_len in 1..2^MAX_LEN_LOG2 goes to len_shadow.
  - cfg_len of 0 or above 2^MAX_LEN_LOG2 is ignored and sets cfg_err.
  - len_shadow is copied to len_active only in IDLE, or when the read address wraps to 0.
- FSM states:
  - IDLE → RUN when enable=1. Read address resets to 0 and len_active is loaded.
  - RUN: issue one RAM read per cycle when (FIFO occupancy + reads in flight) < 2. After issuing the read at address len_active-1, wrap the address to 0.
  - RUN → DRAIN when enable=0. No new vector starts after that point.
  - DRAIN: keep issuing reads until the entry with last=1 has been issued, then stop. Go to IDLE once that beat is accepted (o_tvalid & o_tready) and the FIFO is empty.
  - Re-asserting enable during DRAIN does not cancel the drain. IDLE re-evaluates enable on the next cycle.
- The last flag travels with each read: last = (addr == len_active-1).
- Output path:
  - 2-entry FIFO/skid buffer, registered outputs.
  - o_tdata and o_tlast must hold steady while o_tvalid=1 and o_tready=0.
- Latency and throughput:
  - enable rising to first o_tvalid is 2 cycles (address issue, then RAM read into the FIFO/output register).
  - Sustained rate is 1 beat per cycle while o_tready=1.
  - No bubbles at vector wrap.
- len_active=1: every beat has o_tlast=1 and carries entry 0.
- Asynchronous reset mid-run: outputs clear immediately. Any partial vector is discarded.

Optional Feature:
- Macro: CVEC_PLAYER_CONJ_EN.
- With the macro defined:
  - Add input port conj (1 bit), sampled at each vector start.
  - When conj=1, the output is the conjugate: Q is negated with saturation, so -32768 becomes 32767.
  - Costs no extra latency; the negation is applied on the RAM output before the FIFO.
- Without the macro: no conj port; data passes unmodified.

Decomposition:
- Shared header cvec_player_defs.vh holds:
  - IQ field positions (I_MSB=31, I_LSB=16, Q_MSB=15, Q_LSB=0).
  - FSM state encodings (IDLE, RUN, DRAIN).
  - FIFO depth constant (2).
- One sub-module, cvec_ram: parameterised simple dual-port RAM with registered read, inferred as BRAM.

Test Plan:
- Basic replay:
  - Stimulus: load entries 0..3 with {I=k, Q=-k}, cfg_len=4, enable=1, o_tready=1.
  - Required: first o_tvalid 2 cycles after enable. Beats 0x0000_0000, 0x0001_FFFF, 0x0002_FFFE, 0x0003_FFFD repeat, with o_tlast on every 4th beat.
- Backpressure:
  - Stimulus: same setup, o_tready toggled with a random 50% pattern.
  - Required: no dropped or duplicated beats; o_tdata and o_tlast stable while stalled.
- Length change:
  - Stimulus: while running with len=4, write cfg_len=2 during beat index 1.
  - Required: the current vector still completes 4 beats; subsequent vectors are 2 beats. cfg_len=0 sets cfg_err and does not change the length.
- Stop and restart:
  - Stimulus: deassert enable at beat index 1 of a len-4 vector.
  - Required: beats 2 and 3 are still emitted with tlast on beat 3, then busy=0. Re-enabling restarts at entry 0.
- Edge cases:
  - len=1: a continuous stream of entry 0, all beats with tlast=1.
  - reset_n pulsed mid-vector: o_tvalid=0 asynchronously, and after release the stream restarts from entry 0.
- Conjugation (with CVEC_PLAYER_CONJ_EN defined):
  - Stimulus: entry {I=0x1234, Q=0x8000}, conj=1.
  - Required: output 0x1234_7FFF. With conj=0 the output is 0x1234_8000.
